// File: rtl/sid_dac_pkg.sv
// Shared types and constants for the SID stereo DAC7611 serialiser.
package sid_dac_pkg;

  // Frame sequencer states: one LOW/HIGH pair per bit, then the latch pulse and a guard gap.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOW   = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LATCH = 3'd3,
    ST_GAP   = 3'd4
  } dac_state_t;

  localparam int DAC_W_DEFAULT   = 12;
  localparam int CLK_DIV_DEFAULT = 2;

  // Cycles per frame: DAC_W clock periods plus the latch phase and the gap phase.
  function automatic int frame_len(input int dac_w, input int clk_div);
    return (2 * dac_w + 2) * clk_div;
  endfunction

  localparam int FRAME_LEN_DEFAULT = frame_len(DAC_W_DEFAULT, CLK_DIV_DEFAULT);

endpackage

// File: rtl/sid_dac_tick.sv
// Phase timer: a down-counter that marks the last cycle of every CLK_DIV-long phase.
module sid_dac_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic wb_clk_i,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = 8;

  logic [CW-1:0] cnt;

  // Reload on every state change; otherwise count down and park at zero.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= CW'(CLK_DIV - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Zero means the current phase has run its full CLK_DIV cycles.
  assign tick = (cnt == '0);

endmodule

// File: rtl/sid_dac_ctrl.sv
// Stereo serialiser for a pair of DAC7611 converters sharing clock and load strobe.
module sid_dac_ctrl
  import sid_dac_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int DAC_W   = DAC_W_DEFAULT
) (
  input  logic             wb_clk_i,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DAC_W-1:0] s_left,
  input  logic [DAC_W-1:0] s_right,
  output logic             dac_clk,
  output logic             dac_dat1,
  output logic             dac_dat2,
  output logic             dac_le_b,
  output logic             busy
);

  localparam int BW = (DAC_W > 1) ? $clog2(DAC_W) : 1;

  dac_state_t       state, state_next;
  logic [DAC_W-1:0] hold_l, hold_r;
  logic             hold_full;
  logic [DAC_W-1:0] sh_l, sh_r, sh_l_next, sh_r_next;
  logic [BW-1:0]    bit_cnt, bit_next;
  logic             load;
  logic             accept;
  logic             tick;
  logic             restart;

  assign s_ready = !hold_full;
  assign accept  = s_valid && !hold_full;
  assign busy    = (state != ST_IDLE);
  assign restart = (state_next != state);

  sid_dac_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .wb_clk_i (wb_clk_i),
    .rst_n    (rst_n),
    .restart  (restart),
    .tick     (tick)
  );

  // Next-state, bit counter and shift-register load decisions.
  always_comb begin
    state_next = state;
    bit_next   = bit_cnt;
    sh_l_next  = sh_l;
    sh_r_next  = sh_r;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hold_full) begin
          load       = 1'b1;
          sh_l_next  = hold_l;
          sh_r_next  = hold_r;
          bit_next   = BW'(DAC_W - 1);
          state_next = ST_LOW;
        end
      end
      ST_LOW: begin
        if (tick) state_next = ST_HIGH;
      end
      ST_HIGH: begin
        if (tick) begin
          if (bit_cnt == '0) begin
            state_next = ST_LATCH;
          end else begin
            bit_next   = bit_cnt - 1'b1;
            state_next = ST_LOW;
          end
        end
      end
      ST_LATCH: begin
        if (tick) state_next = ST_GAP;
      end
      ST_GAP: begin
        if (tick) begin
          if (hold_full) begin
            // Back-to-back: the next frame starts with no idle cycle.
            load       = 1'b1;
            sh_l_next  = hold_l;
            sh_r_next  = hold_r;
            bit_next   = BW'(DAC_W - 1);
            state_next = ST_LOW;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // One-deep holding register; accept and load can never coincide since s_ready gates accept.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_l    <= s_left;
      hold_r    <= s_right;
    end
  end

  // Sequencer state, bit index and the two shift registers.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      sh_l    <= '0;
      sh_r    <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_next;
      sh_l    <= sh_l_next;
      sh_r    <= sh_r_next;
    end
  end

  // Pin drivers registered from the next state so they change exactly on phase entry.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      dac_clk  <= 1'b0;
      dac_le_b <= 1'b1;
      dac_dat1 <= 1'b0;
      dac_dat2 <= 1'b0;
    end else begin
      dac_clk  <= (state_next == ST_HIGH);
      dac_le_b <= (state_next != ST_LATCH);
      case (state_next)
        ST_LOW: begin
          dac_dat1 <= sh_l_next[bit_next];
          dac_dat2 <= sh_r_next[bit_next];
        end
        ST_HIGH: begin
          // Data held stable across the rising edge.
          dac_dat1 <= dac_dat1;
          dac_dat2 <= dac_dat2;
        end
        default: begin
          dac_dat1 <= 1'b0;
          dac_dat2 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sid_dac_ctrl.sv
// Self-checking bench: two instances (CLK_DIV 2 and 1) observed by a DAC7611 pin-level model.
module tb_sid_dac_ctrl;

  typedef struct {
    int          inst;
    logic [11:0] l;
    logic [11:0] r;
    int          rises;
    int          le_len;
    int          fall_cyc;
    int          fall_delay;
    int          first_rise;
  } frame_t;

  typedef struct {
    int          inst;
    logic [11:0] l;
    logic [11:0] r;
  } exp_t;

  localparam int FRAME_A = (2 * 12 + 2) * 2;
  localparam int FRAME_B = (2 * 12 + 2) * 1;

  logic        wb_clk_i = 1'b0;
  logic        rst_n;
  logic        s_valid_a, s_valid_b;
  logic [11:0] s_left_a, s_right_a, s_left_b, s_right_b;
  logic        s_ready_a, s_ready_b;
  logic        dac_clk_a, dac_dat1_a, dac_dat2_a, dac_le_b_a, busy_a;
  logic        dac_clk_b, dac_dat1_b, dac_dat2_b, dac_le_b_b, busy_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  frame_t frames[$];
  exp_t   exp_q[$];

  logic [11:0] m_sh_l[2];
  logic [11:0] m_sh_r[2];
  int          m_rises[2];
  int          m_first[2];
  int          m_last_rise[2];
  int          m_fall[2];
  int          le_falls[2] = '{0, 0};
  logic        m_pclk[2];
  logic        m_ple[2];

  always #5 wb_clk_i = ~wb_clk_i;

  always @(posedge wb_clk_i) cyc <= cyc + 1;

  sid_dac_ctrl #(.CLK_DIV(2), .DAC_W(12)) dut_a (
    .wb_clk_i (wb_clk_i), .rst_n (rst_n),
    .s_valid  (s_valid_a), .s_ready (s_ready_a),
    .s_left   (s_left_a), .s_right (s_right_a),
    .dac_clk  (dac_clk_a), .dac_dat1 (dac_dat1_a), .dac_dat2 (dac_dat2_a),
    .dac_le_b (dac_le_b_a), .busy (busy_a)
  );

  sid_dac_ctrl #(.CLK_DIV(1), .DAC_W(12)) dut_b (
    .wb_clk_i (wb_clk_i), .rst_n (rst_n),
    .s_valid  (s_valid_b), .s_ready (s_ready_b),
    .s_left   (s_left_b), .s_right (s_right_b),
    .dac_clk  (dac_clk_b), .dac_dat1 (dac_dat1_b), .dac_dat2 (dac_dat2_b),
    .dac_le_b (dac_le_b_b), .busy (busy_b)
  );

  // DAC7611 pair model: shift on each dac_clk rise, capture a frame when the load strobe ends.
  always @(negedge wb_clk_i) begin : dac_model
    for (int k = 0; k < 2; k++) begin
      logic   c, d1, d2, le;
      frame_t fr;
      c  = (k == 0) ? dac_clk_a  : dac_clk_b;
      d1 = (k == 0) ? dac_dat1_a : dac_dat1_b;
      d2 = (k == 0) ? dac_dat2_a : dac_dat2_b;
      le = (k == 0) ? dac_le_b_a : dac_le_b_b;
      if (!rst_n) begin
        m_sh_l[k]  <= '0;
        m_sh_r[k]  <= '0;
        m_rises[k] <= 0;
        m_pclk[k]  <= 1'b0;
        m_ple[k]   <= 1'b1;
      end else begin
        if (c && !m_pclk[k]) begin
          m_sh_l[k] <= {m_sh_l[k][10:0], d1};
          m_sh_r[k] <= {m_sh_r[k][10:0], d2};
          if (m_rises[k] == 0) m_first[k] <= cyc;
          m_rises[k]     <= m_rises[k] + 1;
          m_last_rise[k] <= cyc;
        end
        if (!le && m_ple[k]) begin
          m_fall[k]   <= cyc;
          le_falls[k] <= le_falls[k] + 1;
        end
        if (le && !m_ple[k]) begin
          fr.inst       = k;
          fr.l          = m_sh_l[k];
          fr.r          = m_sh_r[k];
          fr.rises      = m_rises[k];
          fr.le_len     = cyc - m_fall[k];
          fr.fall_cyc   = m_fall[k];
          fr.fall_delay = m_fall[k] - m_last_rise[k];
          fr.first_rise = m_first[k];
          frames.push_back(fr);
          m_rises[k] <= 0;
        end
        m_pclk[k] <= c;
        m_ple[k]  <= le;
      end
    end
  end

  task automatic step();
    @(negedge wb_clk_i);
    #1;
  endtask

  task automatic set_in(input int inst, input logic v, input logic [11:0] l, input logic [11:0] r);
    if (inst == 0) begin
      s_valid_a = v; s_left_a = l; s_right_a = r;
    end else begin
      s_valid_b = v; s_left_b = l; s_right_b = r;
    end
  endtask

  // Offer a pair until accepted; returns the accepting edge index and whether a frame was running.
  task automatic send(input int inst, input logic [11:0] l, input logic [11:0] r, input bit keep,
                      output int acc_cyc, output bit was_busy);
    bit   acc;
    bit   rdy;
    int   n;
    exp_t e;
    acc = 1'b0; n = 0; was_busy = 1'b0;
    set_in(inst, 1'b1, l, r);
    while (!acc && n < 500) begin
      rdy      = (inst == 0) ? s_ready_a : s_ready_b;
      was_busy = (inst == 0) ? busy_a : busy_b;
      @(posedge wb_clk_i);
      acc = rdy;
      n++;
      step();
    end
    acc_cyc = cyc;
    if (!keep) set_in(inst, 1'b0, l, r);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: inst %0d not accepted after %0d cycles (required accept)", inst, n);
    end else begin
      e.inst = inst; e.l = l; e.r = r;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_frame(output frame_t f, output bit ok);
    int n;
    n = 0;
    while (frames.size() == 0 && n < 400) begin
      step();
      n++;
    end
    ok = (frames.size() != 0);
    if (ok) f = frames.pop_front();
  endtask

  task automatic test_reset();
    set_in(0, 1'b0, 12'h000, 12'h000);
    set_in(1, 1'b0, 12'h000, 12'h000);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    step();
    checks++; if (dac_clk_a !== 1'b0)  begin errors++; $display("FAIL rst_dac_clk: got %b expected 0", dac_clk_a); end
    checks++; if (dac_dat1_a !== 1'b0) begin errors++; $display("FAIL rst_dat1: got %b expected 0", dac_dat1_a); end
    checks++; if (dac_dat2_a !== 1'b0) begin errors++; $display("FAIL rst_dat2: got %b expected 0", dac_dat2_a); end
    checks++; if (dac_le_b_a !== 1'b1) begin errors++; $display("FAIL rst_le_b: got %b expected 1", dac_le_b_a); end
    checks++; if (busy_a !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b expected 0", busy_a); end
    checks++; if (s_ready_a !== 1'b1)  begin errors++; $display("FAIL rst_s_ready: got %b expected 1", s_ready_a); end
    checks++; if ({s_ready_b, dac_le_b_b, busy_b, dac_clk_b} !== 4'b1100)
      begin errors++; $display("FAIL rst_inst_b: got %b expected 1100", {s_ready_b, dac_le_b_b, busy_b, dac_clk_b}); end
    rst_n = 1'b1;
    repeat (2) step();
    checks++; if (busy_a !== 1'b0 || s_ready_a !== 1'b1)
      begin errors++; $display("FAIL post_rst_idle: busy %b ready %b expected 0 1", busy_a, s_ready_a); end
  endtask

  task automatic test_single();
    int     acc, n;
    bit     wb, ok;
    frame_t f;
    exp_t   e;
    send(0, 12'hA5C, 12'h3F0, 1'b0, acc, wb);
    checks++; if (s_ready_a !== 1'b0) begin errors++; $display("FAIL single_ready_low: got %b expected 0", s_ready_a); end
    step();
    checks++; if (s_ready_a !== 1'b1) begin errors++; $display("FAIL single_ready_one_cycle: got %b expected 1", s_ready_a); end
    n = 0;
    while (busy_a && n < 300) begin n++; step(); end
    checks++; if (n != FRAME_A) begin errors++; $display("FAIL single_busy_len: got %0d expected %0d", n, FRAME_A); end
    wait_frame(f, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL single_frame_timeout: no latch seen (required one)");
    end else begin
      e = exp_q.pop_front();
      checks++; if (f.l !== e.l) begin errors++; $display("FAIL single_left: got %h expected %h", f.l, e.l); end
      checks++; if (f.r !== e.r) begin errors++; $display("FAIL single_right: got %h expected %h", f.r, e.r); end
      checks++; if (f.rises != 12) begin errors++; $display("FAIL single_rises: got %0d expected 12", f.rises); end
      checks++; if (f.le_len != 2) begin errors++; $display("FAIL single_le_len: got %0d expected 2", f.le_len); end
      checks++; if (f.fall_delay != 2) begin errors++; $display("FAIL single_le_delay: got %0d expected 2", f.fall_delay); end
      checks++; if (f.first_rise - acc != 3)
        begin errors++; $display("FAIL single_first_rise: got %0d expected 3", f.first_rise - acc); end
    end
  endtask

  task automatic test_back_to_back();
    int     acc[4];
    bit     wb[4];
    bit     ok;
    int     prev_fall;
    frame_t f;
    exp_t   e;
    for (int i = 0; i < 4; i++) begin
      send(0, 12'($urandom), 12'($urandom), 1'b1, acc[i], wb[i]);
    end
    set_in(0, 1'b0, 12'h000, 12'h000);
    for (int i = 1; i < 4; i++) begin
      checks++; if (!wb[i]) begin errors++; $display("FAIL b2b_mid_frame[%0d]: accept while idle, required mid-frame", i); end
    end
    prev_fall = 0;
    for (int i = 0; i < 4; i++) begin
      wait_frame(f, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL b2b_frame_timeout[%0d]: no latch seen", i);
      end else begin
        e = exp_q.pop_front();
        checks++; if ({f.l, f.r} !== {e.l, e.r})
          begin errors++; $display("FAIL b2b_data[%0d]: got %h/%h expected %h/%h", i, f.l, f.r, e.l, e.r); end
        if (i > 0) begin
          checks++; if (f.fall_cyc - prev_fall != FRAME_A)
            begin errors++; $display("FAIL b2b_pitch[%0d]: got %0d expected %0d", i, f.fall_cyc - prev_fall, FRAME_A); end
        end
        prev_fall = f.fall_cyc;
      end
    end
  endtask

  task automatic test_stall();
    int     acc, viol;
    bit     wb, ok;
    frame_t f;
    exp_t   e;
    send(0, 12'($urandom), 12'($urandom), 1'b0, acc, wb);
    viol = 0;
    for (int n = 0; n < 200; n++) begin
      step();
      if (n >= 60 && (dac_clk_a !== 1'b0 || dac_le_b_a !== 1'b1 || busy_a !== 1'b0)) viol++;
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL stall_idle_pins: %0d bad cycles, expected 0", viol); end
    checks++; if (frames.size() != 1) begin errors++; $display("FAIL stall_frame_count: got %0d expected 1", frames.size()); end
    wait_frame(f, ok);
    if (ok) begin
      e = exp_q.pop_front();
      checks++; if ({f.l, f.r} !== {e.l, e.r})
        begin errors++; $display("FAIL stall_data: got %h/%h expected %h/%h", f.l, f.r, e.l, e.r); end
    end
    frames.delete();
  endtask

  task automatic test_clkdiv1();
    int     acc;
    bit     wb, ok;
    int     prev_fall;
    frame_t f;
    exp_t   e;
    send(1, 12'hFFF, 12'h000, 1'b1, acc, wb);
    send(1, 12'h000, 12'hFFF, 1'b0, acc, wb);
    prev_fall = 0;
    for (int i = 0; i < 2; i++) begin
      wait_frame(f, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL div1_frame_timeout[%0d]: no latch seen", i);
      end else begin
        e = exp_q.pop_front();
        checks++; if (f.inst != 1 || {f.l, f.r} !== {e.l, e.r})
          begin errors++; $display("FAIL div1_data[%0d]: got %h/%h expected %h/%h", i, f.l, f.r, e.l, e.r); end
        checks++; if (f.rises != 12 || f.le_len != 1)
          begin errors++; $display("FAIL div1_shape[%0d]: rises %0d le %0d expected 12 1", i, f.rises, f.le_len); end
        if (i > 0) begin
          checks++; if (f.fall_cyc - prev_fall != FRAME_B)
            begin errors++; $display("FAIL div1_pitch: got %0d expected %0d", f.fall_cyc - prev_fall, FRAME_B); end
        end
        prev_fall = f.fall_cyc;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int     acc, n, falls0;
    bit     wb, ok;
    frame_t f;
    exp_t   e;
    send(0, 12'($urandom), 12'($urandom), 1'b0, acc, wb);
    n = 0;
    while (m_rises[0] != 5 && n < 300) begin step(); n++; end
    checks++; if (m_rises[0] != 5) begin errors++; $display("FAIL midrst_wait: got %0d rises expected 5", m_rises[0]); end
    falls0 = le_falls[0];
    rst_n = 1'b0;
    #1;
    checks++; if ({dac_clk_a, dac_dat1_a, dac_dat2_a, dac_le_b_a, busy_a, s_ready_a} !== 6'b000101)
      begin errors++; $display("FAIL midrst_outputs: got %b expected 000101",
                               {dac_clk_a, dac_dat1_a, dac_dat2_a, dac_le_b_a, busy_a, s_ready_a}); end
    repeat (2) step();
    rst_n = 1'b1;
    void'(exp_q.pop_front());
    repeat (3) step();
    checks++; if (le_falls[0] != falls0) begin errors++; $display("FAIL midrst_le_pulse: got %0d falls expected %0d", le_falls[0], falls0); end
    checks++; if (frames.size() != 0) begin errors++; $display("FAIL midrst_latched: got %0d frames expected 0", frames.size()); end
    send(0, 12'($urandom), 12'($urandom), 1'b0, acc, wb);
    wait_frame(f, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL midrst_frame_timeout: no latch after release");
    end else begin
      e = exp_q.pop_front();
      checks++; if ({f.l, f.r} !== {e.l, e.r} || f.rises != 12)
        begin errors++; $display("FAIL midrst_next: got %h/%h rises %0d expected %h/%h 12", f.l, f.r, f.rises, e.l, e.r); end
    end
  endtask

  task automatic test_simultaneous();
    int     acc, n;
    bit     wb, ok;
    frame_t f;
    exp_t   e;
    send(0, 12'($urandom), 12'($urandom), 1'b0, acc, wb);
    n = 0;
    while (dac_le_b_a !== 1'b0 && n < 200) begin step(); n++; end
    while (dac_le_b_a !== 1'b1 && n < 200) begin step(); n++; end
    step();
    send(0, 12'($urandom), 12'($urandom), 1'b0, acc, wb);
    checks++; if (busy_a !== 1'b0 || s_ready_a !== 1'b0)
      begin errors++; $display("FAIL simul_idle: busy %b ready %b expected 0 0", busy_a, s_ready_a); end
    step();
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL simul_low: busy %b expected 1", busy_a); end
    for (int i = 0; i < 2; i++) begin
      wait_frame(f, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL simul_frame_timeout[%0d]: no latch seen", i);
      end else begin
        e = exp_q.pop_front();
        checks++; if ({f.l, f.r} !== {e.l, e.r})
          begin errors++; $display("FAIL simul_data[%0d]: got %h/%h expected %h/%h", i, f.l, f.r, e.l, e.r); end
        if (i == 0) begin
          checks++; if (acc - f.fall_cyc != 4)
            begin errors++; $display("FAIL simul_edge: accept %0d cycles after latch, expected 4", acc - f.fall_cyc); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_clkdiv1();
    test_reset_mid_frame();
    test_simultaneous();
    repeat (5) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
